axi_slave_regs: RTL and testbench
=================================

// Module: axi_slave_regs
// PURPOSE
//  AXI4-Lite responder exposing N_REGS 32-bit read/write registers to an AXI initiator.
//  Terminates the AR/R/AW/W/B channels driven by the SoC's handshake-to-AXI master.
//  Drives register contents and per-register write pulses to peripheral logic.
//  Single outstanding transaction; reads have priority over writes.
// PARAMETERS
//  N_REGS     8      number of 32-bit registers; power of two, >=2; IDXW = log2(N_REGS)
//  BASE_ADDR  32'h0  base byte address; must be aligned to N_REGS*4
// PORTS
//  clk_i      in   1           clock, all logic on rising edge
//  rst_i      in   1           synchronous reset, active-low
//  arvalid_i  in   1           read address valid
//  arready_o  out  1           read address ready
//  araddr_i   in   32          read byte address
//  rvalid_o   out  1           read data valid
//  rready_i   in   1           read data ready
//  rdata_o    out  32          read data
//  rresp_o    out  2           read response
//  awvalid_i  in   1           write address valid
//  awready_o  out  1           write address ready
//  awaddr_i   in   32          write byte address
//  wvalid_i   in   1           write data valid
//  wready_o   out  1           write data ready
//  wdata_i    in   32          write data
//  bvalid_o   out  1           write response valid
//  bready_i   in   1           write response ready
//  bresp_o    out  2           write response
//  regs_o     out  N_REGS*32   register contents; reg i at [32*i+:32]
//  wr_pulse_o out  N_REGS      1-cycle pulse when reg i is written
// BEHAVIOUR
//  - Reset (rst_i=0 at a clock edge): state=IDLE; all regs, rdata_o, rresp_o, bresp_o = 0;
//    rvalid_o, bvalid_o, wr_pulse_o = 0. All readies are 0 while rst_i=0. Reset aborts any
//    transaction in flight; pending responses are dropped.
//  - Decode: in range iff addr[31:2+IDXW]==BASE_ADDR[31:2+IDXW]; idx=addr[2+:IDXW].
//    resp: addr[1:0]!=0 -> SLVERR 2'b10; else out of range -> DECERR 2'b11; else OKAY 2'b00.
//    Unaligned takes precedence over out of range.
//  - States: IDLE, W_NEED_W, W_NEED_AW, W_COMMIT, B_RESP, R_RESP.
//  - Readies are combinational from state and valids:
//    arready_o = IDLE.
//    awready_o = (IDLE & !arvalid_i) | W_NEED_AW.
//    wready_o  = (IDLE & !arvalid_i) | W_NEED_W.
//  - IDLE transitions:
//    arvalid -> R_RESP; araddr decoded, rdata_o <= OKAY ? reg[idx] : 0, rresp_o latched.
//    Else awvalid&wvalid -> W_COMMIT. Else awvalid alone -> W_NEED_W.
//    Else wvalid alone -> W_NEED_AW. Address and data are latched at their handshakes.
//  - W_NEED_W: on wvalid_i -> W_COMMIT. W_NEED_AW: on awvalid_i -> W_COMMIT.
//  - W_COMMIT (exactly 1 cycle): if OKAY, reg[idx] <= wdata at cycle end and
//    wr_pulse_o[idx]=1 during this cycle; else no register change and no pulse.
//    bresp_o latched; next state B_RESP.
//  - B_RESP: bvalid_o=1, bresp_o stable until bready_i; then IDLE.
//  - R_RESP: rvalid_o=1, rdata_o/rresp_o stable until rready_i; then IDLE.
//  - Latency:
//    AR handshake at edge k -> rvalid_o=1 from cycle k+1.
//    Final AW/W handshake at edge k -> W_COMMIT in cycle k+1; bvalid_o=1 from cycle k+2.
//    A read issued after B completes returns the new value.
//  - Simultaneous arvalid and awvalid/wvalid in IDLE: only the read is accepted; AW/W
//    stay pending and are accepted after the read response.
//  - No wstrb: writes are full 32-bit words. Back-to-back transactions need 1 IDLE cycle
//    between them.
// TESTING
//  1. Write 0xDEADBEEF to 0x04 with AW/W together, bready=1 -> W_COMMIT 1 cycle later,
//     wr_pulse_o=8'h02, bvalid 2 cycles after handshake, bresp=00; regs_o[63:32]=0xDEADBEEF.
//  2. AW at 0x08 first, W 3 cycles later (0x1234); then repeat with W first, AW later ->
//     both writes commit, bresp=00, reg2=0x1234.
//  3. Read 0x04 with rready held low 4 cycles -> rvalid stays 1, rdata=0xDEADBEEF stable,
//     rresp=00; rvalid drops the cycle after rready=1.
//  4. Write 0x06 -> bresp=10; write 0x100 (BASE 0) -> bresp=11; no reg change, no pulse;
//     read 0x100 -> rdata=0, rresp=11.
//  5. arvalid (0x00) and awvalid/wvalid (0x0C, 0x55) in the same IDLE cycle -> read
//     served first with old reg0, then write accepted, reg3=0x55.
//  6. Assert rst_i=0 while in B_RESP and while in R_RESP -> next cycle bvalid=rvalid=0,
//     regs_o all 0, readies 0 during reset, IDLE afterwards.

Source files
------------

// File: rtl/axi_slave_regs.sv
// AXI4-Lite register file: N_REGS 32-bit read/write registers, one outstanding transaction,
// reads win over writes when both are presented in the same idle cycle.
module axi_slave_regs #(
    parameter int unsigned N_REGS    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 arvalid_i,
    output logic                 arready_o,
    input  logic [31:0]          araddr_i,
    output logic                 rvalid_o,
    input  logic                 rready_i,
    output logic [31:0]          rdata_o,
    output logic [1:0]           rresp_o,
    input  logic                 awvalid_i,
    output logic                 awready_o,
    input  logic [31:0]          awaddr_i,
    input  logic                 wvalid_i,
    output logic                 wready_o,
    input  logic [31:0]          wdata_i,
    output logic                 bvalid_o,
    input  logic                 bready_i,
    output logic [1:0]           bresp_o,
    output logic [N_REGS*32-1:0] regs_o,
    output logic [N_REGS-1:0]    wr_pulse_o
);

    localparam int unsigned IDXW = $clog2(N_REGS);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StWNeedW,
        StWNeedAw,
        StWCommit,
        StBResp,
        StRResp
    } state_e;

    state_e                  state_q;
    logic [N_REGS-1:0][31:0] regs_q;
    logic [31:0]             rdata_q;
    logic [1:0]              rresp_q;
    logic [1:0]              bresp_q;
    logic [31:0]             waddr_q;
    logic [31:0]             wdata_q;

    logic [1:0]              ar_resp;
    logic [1:0]              w_resp;
    logic [IDXW-1:0]         ar_idx;
    logic [IDXW-1:0]         w_idx;

    // Misalignment is reported ahead of an out-of-window address.
    function automatic logic [1:0] decode(input logic [31:0] addr);
        if (addr[1:0] != 2'b00) begin
            return RespSlvErr;
        end
        if (addr[31:2+IDXW] != BASE_ADDR[31:2+IDXW]) begin
            return RespDecErr;
        end
        return RespOkay;
    endfunction

    assign ar_resp = decode(araddr_i);
    assign ar_idx  = araddr_i[2+:IDXW];
    assign w_resp  = decode(waddr_q);
    assign w_idx   = waddr_q[2+:IDXW];

    always_comb begin
        arready_o  = rst_i && (state_q == StIdle);
        awready_o  = rst_i && (((state_q == StIdle) && !arvalid_i) || (state_q == StWNeedAw));
        wready_o   = rst_i && (((state_q == StIdle) && !arvalid_i) || (state_q == StWNeedW));
        rvalid_o   = (state_q == StRResp);
        bvalid_o   = (state_q == StBResp);
        wr_pulse_o = '0;
        if ((state_q == StWCommit) && (w_resp == RespOkay)) begin
            wr_pulse_o[w_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            regs_q  <= '0;
            rdata_q <= '0;
            rresp_q <= '0;
            bresp_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (arvalid_i) begin
                        rresp_q <= ar_resp;
                        rdata_q <= (ar_resp == RespOkay) ? regs_q[ar_idx] : '0;
                        state_q <= StRResp;
                    end else if (awvalid_i && wvalid_i) begin
                        waddr_q <= awaddr_i;
                        wdata_q <= wdata_i;
                        state_q <= StWCommit;
                    end else if (awvalid_i) begin
                        waddr_q <= awaddr_i;
                        state_q <= StWNeedW;
                    end else if (wvalid_i) begin
                        wdata_q <= wdata_i;
                        state_q <= StWNeedAw;
                    end
                end
                StWNeedW: begin
                    if (wvalid_i) begin
                        wdata_q <= wdata_i;
                        state_q <= StWCommit;
                    end
                end
                StWNeedAw: begin
                    if (awvalid_i) begin
                        waddr_q <= awaddr_i;
                        state_q <= StWCommit;
                    end
                end
                StWCommit: begin
                    if (w_resp == RespOkay) begin
                        regs_q[w_idx] <= wdata_q;
                    end
                    bresp_q <= w_resp;
                    state_q <= StBResp;
                end
                StBResp: begin
                    if (bready_i) begin
                        state_q <= StIdle;
                    end
                end
                StRResp: begin
                    if (rready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rdata_o = rdata_q;
    assign rresp_o = rresp_q;
    assign bresp_o = bresp_q;
    assign regs_o  = regs_q;

endmodule

// File: tb/tb_axi_slave_regs.sv
// Directed bench for axi_slave_regs: expected responses are queued when a transaction is
// driven and compared when the matching R or B beat appears.
module tb_axi_slave_regs;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         arvalid_i, arready_o;
    logic [31:0]  araddr_i;
    logic         rvalid_o, rready_i;
    logic [31:0]  rdata_o;
    logic [1:0]   rresp_o;
    logic         awvalid_i, awready_o;
    logic [31:0]  awaddr_i;
    logic         wvalid_i, wready_o;
    logic [31:0]  wdata_i;
    logic         bvalid_o, bready_i;
    logic [1:0]   bresp_o;
    logic [255:0] regs_o;
    logic [7:0]   wr_pulse_o;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_regs[8];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk_i = ~clk_i;

    axi_slave_regs #(.N_REGS(8), .BASE_ADDR(32'h0)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .arvalid_i  (arvalid_i),
        .arready_o  (arready_o),
        .araddr_i   (araddr_i),
        .rvalid_o   (rvalid_o),
        .rready_i   (rready_i),
        .rdata_o    (rdata_o),
        .rresp_o    (rresp_o),
        .awvalid_i  (awvalid_i),
        .awready_o  (awready_o),
        .awaddr_i   (awaddr_i),
        .wvalid_i   (wvalid_i),
        .wready_o   (wready_o),
        .wdata_i    (wdata_i),
        .bvalid_o   (bvalid_o),
        .bready_i   (bready_i),
        .bresp_o    (bresp_o),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Independent address model: 8 words at 0x00..0x1F.
    function automatic logic [1:0] model_resp(input logic [31:0] a);
        if (a % 4 != 0) return 2'b10;
        if (a >= 32) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [255:0] model_regs();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i+:32] = exp_regs[i];
        return v;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) exp_regs[i] = '0;
        sb.delete();
    endtask

    task automatic sb_pop(output exp_t e);
        if (sb.size() == 0) begin
            n_checks++;
            $error("FAIL sb_pop: got empty queue expected an entry");
            e = '{1'b0, 32'h0, 2'b00};
        end else begin
            e = sb.pop_front();
        end
    endtask

    // Entered at the W_COMMIT negedge; bvalid must rise exactly one cycle later.
    task automatic wait_b(input string tag);
        int   n = 0;
        exp_t e;
        while (!bvalid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_b_latency"}, n, 1);
        sb_pop(e);
        check({tag, "_bresp"}, bresp_o, e.resp);
        bready_i = 1'b1;
        @(negedge clk_i);
        check({tag, "_b_drop"}, bvalid_o, 1'b0);
        bready_i = 1'b0;
    endtask

    task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input int aw_dly, input int w_dly, input bit complete);
        bit         aw_done = 0;
        bit         w_done  = 0;
        int         t       = 0;
        logic [1:0] resp;
        logic [7:0] pulse;
        resp  = model_resp(addr);
        pulse = '0;
        if (resp == 2'b00) begin
            pulse[addr/4] = 1'b1;
            exp_regs[addr/4] = data;
        end
        sb.push_back('{1'b0, 32'h0, resp});
        while (!(aw_done && w_done) && t < 50) begin
            @(negedge clk_i);
            awvalid_i = !aw_done && (t >= aw_dly);
            awaddr_i  = addr;
            wvalid_i  = !w_done && (t >= w_dly);
            wdata_i   = data;
            #1;
            if (awvalid_i && awready_o) aw_done = 1;
            if (wvalid_i && wready_o) w_done = 1;
            t++;
        end
        check({tag, "_aw_w_accept"}, {aw_done, w_done}, 2'b11);
        @(negedge clk_i);
        awvalid_i = 1'b0;
        wvalid_i  = 1'b0;
        check({tag, "_wr_pulse"}, wr_pulse_o, pulse);
        check({tag, "_b_early"}, bvalid_o, 1'b0);
        if (complete) wait_b(tag);
    endtask

    task automatic axi_read(input string tag, input logic [31:0] addr, input int hold,
                            input bit complete);
        exp_t       e;
        logic [1:0] resp;
        resp = model_resp(addr);
        sb.push_back('{1'b1, (resp == 2'b00) ? exp_regs[addr/4] : 32'h0, resp});
        @(negedge clk_i);
        arvalid_i = 1'b1;
        araddr_i  = addr;
        #1;
        check({tag, "_arready"}, arready_o, 1'b1);
        @(negedge clk_i);
        arvalid_i = 1'b0;
        check({tag, "_rvalid"}, rvalid_o, 1'b1);
        sb_pop(e);
        check({tag, "_rdata"}, rdata_o, e.data);
        check({tag, "_rresp"}, rresp_o, e.resp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            check({tag, "_hold"}, {rvalid_o, rresp_o, rdata_o}, {1'b1, e.resp, e.data});
        end
        if (complete) begin
            rready_i = 1'b1;
            @(negedge clk_i);
            check({tag, "_r_drop"}, rvalid_o, 1'b0);
            rready_i = 1'b0;
        end
    endtask

    task automatic reset_and_check(input string tag);
        rst_i     = 1'b0;
        arvalid_i = 1'b1;
        awvalid_i = 1'b1;
        wvalid_i  = 1'b1;
        #1;
        check({tag, "_readies"}, {arready_o, awready_o, wready_o}, 3'b000);
        @(negedge clk_i);
        check({tag, "_valids"}, {rvalid_o, bvalid_o, wr_pulse_o}, 10'h0);
        check({tag, "_regs"}, regs_o, 256'h0);
        check({tag, "_resp_data"}, {rdata_o, rresp_o, bresp_o}, 36'h0);
        rst_i     = 1'b1;
        arvalid_i = 1'b0;
        awvalid_i = 1'b0;
        wvalid_i  = 1'b0;
        clear_model();
    endtask

    initial begin
        exp_t e;
        rst_i = 1'b0; arvalid_i = 1'b0; araddr_i = '0; rready_i = 1'b0;
        awvalid_i = 1'b1; awaddr_i = '0; wvalid_i = 1'b1; wdata_i = '0; bready_i = 1'b0;
        clear_model();

        // Power-on reset with write valids up: readies must stay low.
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_readies", {arready_o, awready_o, wready_o}, 3'b000);
        check("rst_outputs", {rvalid_o, bvalid_o, wr_pulse_o, rdata_o, rresp_o, bresp_o}, 46'h0);
        check("rst_regs", regs_o, 256'h0);
        awvalid_i = 1'b0;
        wvalid_i  = 1'b0;
        rst_i     = 1'b1;
        @(negedge clk_i);
        #1;
        check("idle_ready", {arready_o, awready_o, wready_o}, 3'b111);

        axi_write("t1", 32'h04, 32'hDEAD_BEEF, 0, 0, 1);
        check("t1_reg1", regs_o[63:32], 32'hDEAD_BEEF);

        axi_write("t2a", 32'h08, 32'h0000_5678, 0, 3, 1);
        check("t2a_reg2", regs_o[95:64], 32'h0000_5678);
        axi_write("t2b", 32'h08, 32'h0000_1234, 3, 0, 1);
        check("t2b_regs", regs_o, model_regs());

        axi_read("t3", 32'h04, 4, 1);

        axi_write("t4_unal", 32'h06, 32'h1111_1111, 0, 0, 1);
        axi_write("t4_oor", 32'h100, 32'h2222_2222, 0, 0, 1);
        check("t4_regs", regs_o, model_regs());
        axi_read("t4_rd_oor", 32'h100, 0, 1);
        axi_read("t4_rd_unal", 32'h05, 0, 1);

        // Read and write offered together: read first, write waits.
        axi_write("t5_pre", 32'h00, 32'h0BAD_F00D, 0, 0, 1);
        sb.push_back('{1'b1, exp_regs[0], 2'b00});
        exp_regs[3] = 32'h55;
        sb.push_back('{1'b0, 32'h0, 2'b00});
        @(negedge clk_i);
        arvalid_i = 1'b1; araddr_i = 32'h00;
        awvalid_i = 1'b1; awaddr_i = 32'h0C;
        wvalid_i  = 1'b1; wdata_i  = 32'h55;
        #1;
        check("t5_ready_arb", {arready_o, awready_o, wready_o}, 3'b100);
        @(negedge clk_i);
        arvalid_i = 1'b0;
        sb_pop(e);
        check("t5_read", {rvalid_o, rresp_o, rdata_o}, {1'b1, e.resp, e.data});
        #1;
        check("t5_w_blocked", {awready_o, wready_o}, 2'b00);
        rready_i = 1'b1;
        @(negedge clk_i);
        rready_i = 1'b0;
        #1;
        check("t5_w_ready", {rvalid_o, awready_o, wready_o}, 3'b011);
        @(negedge clk_i);
        awvalid_i = 1'b0;
        wvalid_i  = 1'b0;
        check("t5_wr_pulse", wr_pulse_o, 8'h08);
        wait_b("t5");
        check("t5_regs", regs_o, model_regs());

        // Reset during B_RESP, then during R_RESP.
        axi_write("t6_w", 32'h10, 32'hCAFE_0001, 0, 0, 0);
        @(negedge clk_i);
        check("t6_in_bresp", bvalid_o, 1'b1);
        reset_and_check("t6_rst_b");
        axi_write("t6_w2", 32'h10, 32'hCAFE_0002, 0, 0, 1);
        axi_read("t6_r", 32'h10, 0, 0);
        reset_and_check("t6_rst_r");
        axi_read("t6_after", 32'h10, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
